// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
// The state encodings are shared so that benches and debug logic decode them the same way.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator for one payload word.
// With par_typ_i = 0 the result gives even parity; with par_typ_i = 1 it gives odd parity.
module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  assign par_bit_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: latches a byte, starts the external serializer, and sequences
// the frame START -> DATA -> [PARITY] -> STOP on TX_OUT, sending one bit per clock.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_pdata,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_bit_in;
  logic                  accept;

  // Parity is taken from the incoming byte so that it is ready in the same edge as the latch.
  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_bit_o (par_bit_in)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE:   accept = Data_Valid;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP: begin
        accept  = Data_Valid;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d   = ST_START;
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = par_bit_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // The line outputs depend only on the state and registered values, never on
  // Data_Valid/P_DATA directly. ser_data comes from the serializer's own shift register.
  always_comb begin
    TX_OUT = LINE_IDLE;
    ser_en = 1'b0;
    case (state_q)
      ST_START: begin
        TX_OUT = START_BIT;
        ser_en = 1'b1;
      end
      ST_DATA:   TX_OUT = ser_data;
      ST_PARITY: TX_OUT = par_bit_q;
      default:   TX_OUT = LINE_IDLE;
    endcase
  end

  assign Busy      = (state_q != ST_IDLE);
  assign ser_pdata = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a simple 8-bit LSB-first serializer model attached.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid, PAR_EN, PAR_TYP;
  logic       ser_done, ser_data, ser_en, TX_OUT, Busy;
  logic [7:0] ser_pdata;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .ser_pdata  (ser_pdata),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Serializer model: loads on ser_en, then presents bit0..bit7 on consecutive cycles.
  logic [7:0] sh;
  logic [2:0] cnt;
  logic       active;
  always @(posedge CLK) begin
    if (!RST) begin
      sh <= 8'h00; cnt <= 3'd0; active <= 1'b0;
    end else if (ser_en) begin
      sh <= ser_pdata; cnt <= 3'd0; active <= 1'b1;
    end else if (active) begin
      sh <= sh >> 1; cnt <= cnt + 3'd1;
      if (cnt == 3'd7) active <= 1'b0;
    end
  end
  assign ser_data = sh[0];
  assign ser_done = active && (cnt == 3'd7);

  typedef struct {
    logic       rst_n;
    logic       dv;
    logic [7:0] pd;
    logic       pe;
    logic       pt;
    logic       tx;
    logic       busy;
    logic       sen;
    logic       chk_pd;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input logic rst_n, input logic dv, input logic [7:0] pd,
                      input logic pe, input logic pt,
                      input logic tx, input logic busy, input logic sen);
    vec_t v;
    v = '{rst_n, dv, pd, pe, pt, tx, busy, sen, 1'b0, 8'h00};
    tbl.push_back(v);
  endtask

  // One row per frame cycle; seq holds the expected TX_OUT bits, first bit in seq[len-1].
  // A request (dv_pd/dv_pe/dv_pt) can be injected at cycle dv_idx of the frame.
  task automatic push_frame(input logic [11:0] seq, input int len, input logic [7:0] byte_v,
                            input int dv_idx, input logic [7:0] dv_pd,
                            input logic dv_pe, input logic dv_pt);
    vec_t v;
    for (int i = 0; i < len; i++) begin
      v = '{1'b1, (i == dv_idx), (i == dv_idx) ? dv_pd : 8'h00,
            (i == dv_idx) ? dv_pe : 1'b0, (i == dv_idx) ? dv_pt : 1'b0,
            seq[len-1-i], 1'b1, (i == 0), (i == 0), byte_v};
      tbl.push_back(v);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    RST = v.rst_n; Data_Valid = v.dv; P_DATA = v.pd; PAR_EN = v.pe; PAR_TYP = v.pt;
    #1;
    n_vec++;
    if (TX_OUT !== v.tx || Busy !== v.busy || ser_en !== v.sen ||
        (v.chk_pd && ser_pdata !== v.exp_pd)) begin
      n_err++;
      $display("FAIL %s: tx/busy/ser_en/pdata got %b%b%b/%h exp %b%b%b/%h",
               tag, TX_OUT, Busy, ser_en, ser_pdata, v.tx, v.busy, v.sen, v.exp_pd);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    vec_t v;
    RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(posedge CLK); #1;

    // Reset held with a pending request: line idle, nothing accepted.
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      apply(v, $sformatf("reset_hold%0d", i));
    end
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    apply(v, "post_reset_idle");

    // 0xA5, no parity
    push(1, 1, 8'hA5, 0, 0, 1, 0, 0);
    push_frame(12'b0101001011, 10, 8'hA5, -1, 8'h00, 0, 0);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);
    // 0xA5, even parity -> 0
    push(1, 1, 8'hA5, 1, 0, 1, 0, 0);
    push_frame(12'b01010010101, 11, 8'hA5, -1, 8'h00, 0, 0);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);
    // 0xA5, odd parity -> 1
    push(1, 1, 8'hA5, 1, 1, 1, 0, 0);
    push_frame(12'b01010010111, 11, 8'hA5, -1, 8'h00, 0, 0);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);
    // 0x00 then 0xFF requested during its STOP cycle: no gap
    push(1, 1, 8'h00, 0, 0, 1, 0, 0);
    push_frame(12'b0000000001, 10, 8'h00, 9, 8'hFF, 0, 0);
    push_frame(12'b0111111111, 10, 8'hFF, -1, 8'h00, 0, 0);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);
    // 0x81 with a 0x3C request during DATA: ignored
    push(1, 1, 8'h81, 0, 0, 1, 0, 0);
    push_frame(12'b0100000011, 10, 8'h81, 3, 8'h3C, 1, 1);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Mid-frame reset during the 4th data bit of 0x55, then a clean 0x0F frame.
    v = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}; apply(v, "abort_accept");
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55}; apply(v, "abort_start");
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}; apply(v, "abort_d0");
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; apply(v, "abort_d1");
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}; apply(v, "abort_d2");
    v = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; apply(v, "abort_d3_rst");
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}; apply(v, "abort_after");
    tbl.delete();
    push(1, 1, 8'h0F, 0, 0, 1, 0, 0);
    push_frame(12'b0111100001, 10, 8'h0F, -1, 8'h00, 0, 0);
    push(1, 0, 8'h00, 0, 0, 1, 0, 0);
    foreach (tbl[i]) apply(tbl[i], $sformatf("post_abort%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
